// File: rtl/regfile_driver.sv
// Command-side sequencer for the 16x4 strobe-load register file: turns write/read
// commands into one-hot strobe sequences. Optional shadow check: REGFILE_DRV_SHADOW_EN.
module regfile_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [3:0] cmd_addr_a,
  input  logic [3:0] cmd_addr_b,
  input  logic [3:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data_a,
  output logic [3:0] rsp_data_b,
  output logic       rsp_mismatch,
  output logic [3:0] rf_p,
  output logic       rf_setRR1,
  output logic       rf_setRR2,
  output logic       rf_setWR,
  output logic       rf_setWData,
  output logic       rf_Wenable,
  input  logic [3:0] rf_OutR1,
  input  logic [3:0] rf_OutR2,
  output logic [3:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid holds its payload stable until that edge, ready may change freely.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    W_ADDR = 4'd1,
    W_DATA = 4'd2,
    W_EN   = 4'd3,
    R_A    = 4'd4,
    R_B    = 4'd5,
    R_WAIT = 4'd6,
    R_CAP  = 4'd7,
    RSP    = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] addr_a_q, addr_a_d;
  logic [3:0] addr_b_q, addr_b_d;
  logic [3:0] data_q, data_d;
  logic [3:0] rf_p_q, rf_p_d;
  logic       set_rr1_q, set_rr1_d;
  logic       set_rr2_q, set_rr2_d;
  logic       set_wr_q, set_wr_d;
  logic       set_wd_q, set_wd_d;
  logic       wen_q, wen_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_a_q, rsp_b_q;
  logic       accept;

  assign accept = (state_q == IDLE) && cmd_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_op ? R_A : W_ADDR;
      W_ADDR:  state_d = W_DATA;
      W_DATA:  state_d = W_EN;
      W_EN:    state_d = IDLE;
      R_A:     state_d = R_B;
      R_B:     state_d = R_WAIT;
      R_WAIT:  state_d = R_CAP;
      R_CAP:   state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    addr_a_d    = accept ? cmd_addr_a : addr_a_q;
    addr_b_d    = accept ? cmd_addr_b : addr_b_q;
    data_d      = accept ? cmd_data   : data_q;
    rf_p_d      = 4'd0;
    set_rr1_d   = 1'b0;
    set_rr2_d   = 1'b0;
    set_wr_d    = 1'b0;
    set_wd_d    = 1'b0;
    wen_d       = 1'b0;
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    case (state_d)
      W_ADDR: begin set_wr_d  = 1'b1; rf_p_d = addr_a_d; end
      W_DATA: begin set_wd_d  = 1'b1; rf_p_d = data_d;   end
      W_EN:   wen_d = 1'b1;
      R_A:    begin set_rr1_d = 1'b1; rf_p_d = addr_a_d; end
      R_B:    begin set_rr2_d = 1'b1; rf_p_d = addr_b_d; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_a_q    <= 4'd0;
      addr_b_q    <= 4'd0;
      data_q      <= 4'd0;
      rf_p_q      <= 4'd0;
      set_rr1_q   <= 1'b0;
      set_rr2_q   <= 1'b0;
      set_wr_q    <= 1'b0;
      set_wd_q    <= 1'b0;
      wen_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= 4'd0;
      rsp_b_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      data_q      <= data_d;
      rf_p_q      <= rf_p_d;
      set_rr1_q   <= set_rr1_d;
      set_rr2_q   <= set_rr2_d;
      set_wr_q    <= set_wr_d;
      set_wd_q    <= set_wd_d;
      wen_q       <= wen_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      if (state_q == R_CAP) begin
        rsp_a_q <= rf_OutR1;
        rsp_b_q <= rf_OutR2;
      end
    end
  end

`ifdef REGFILE_DRV_SHADOW_EN
  logic [3:0]  shadow_q [16];
  logic [15:0] shadow_vld_q;
  logic        mismatch_q, mismatch_d;

  always_comb begin
    mismatch_d = mismatch_q;
    if (state_q == R_CAP) begin
      mismatch_d = (shadow_vld_q[addr_a_q] && (rf_OutR1 != shadow_q[addr_a_q])) ||
                   (shadow_vld_q[addr_b_q] && (rf_OutR2 != shadow_q[addr_b_q]));
    end else if ((state_q == RSP) && rsp_ready) begin
      mismatch_d = 1'b0;
    end
  end

  // Shadow contents need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state_q == W_EN) shadow_q[addr_a_q] <= data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_vld_q <= 16'd0;
      mismatch_q   <= 1'b0;
    end else begin
      if (state_q == W_EN) shadow_vld_q[addr_a_q] <= 1'b1;
      mismatch_q <= mismatch_d;
    end
  end

  assign rsp_mismatch = mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data_a  = rsp_a_q;
  assign rsp_data_b  = rsp_b_q;
  assign rf_p        = rf_p_q;
  assign rf_setRR1   = set_rr1_q;
  assign rf_setRR2   = set_rr2_q;
  assign rf_setWR    = set_wr_q;
  assign rf_setWData = set_wd_q;
  assign rf_Wenable  = wen_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_regfile_driver.sv
// Bench for regfile_driver: behavioural 16x4 register file on the rf_* side and a
// plain array reference of register contents; honours REGFILE_DRV_SHADOW_EN.
module tb_regfile_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [3:0] cmd_addr_a, cmd_addr_b, cmd_data;
  logic       rsp_valid, rsp_ready, rsp_mismatch;
  logic [3:0] rsp_data_a, rsp_data_b;
  logic [3:0] rf_p;
  logic       rf_setRR1, rf_setRR2, rf_setWR, rf_setWData, rf_Wenable;
  logic [3:0] rf_OutR1, rf_OutR2;
  logic [3:0] dbg_state;

  regfile_driver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_mismatch(rsp_mismatch),
    .rf_p(rf_p), .rf_setRR1(rf_setRR1), .rf_setRR2(rf_setRR2), .rf_setWR(rf_setWR),
    .rf_setWData(rf_setWData), .rf_Wenable(rf_Wenable),
    .rf_OutR1(rf_OutR1), .rf_OutR2(rf_OutR2), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- register file environment model ----------------
  logic [3:0] rf_mem [16];
  logic [3:0] rr1 = 4'd0, rr2 = 4'd0, wr_a = 4'd0, wr_d = 4'd0;
  logic [3:0] out1 = 4'd0, out2 = 4'd0;
  bit         force_r1_zero = 1'b0;

  always @(posedge clk) begin
    if (rf_setRR1)        rr1 <= rf_p;
    else if (rf_setRR2)   rr2 <= rf_p;
    else if (rf_setWR)    wr_a <= rf_p;
    else if (rf_setWData) wr_d <= rf_p;
    else if (rf_Wenable)  rf_mem[wr_a] <= wr_d;
    out1 <= rf_mem[rr1];
    out2 <= rf_mem[rr2];
  end

  assign rf_OutR1 = force_r1_zero ? 4'd0 : out1;
  assign rf_OutR2 = out2;

  // ---------------- reference model and scoreboard ----------------
  logic [3:0] ref_mem [16];
  bit         ref_vld [16];
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         onehot_viol = 0;
  int         idle_p_viol = 0;
  int         we_count = 0;
`ifdef REGFILE_DRV_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: log {id, p} for each strobe cycle (ids WR=1 WD=2 WE=3 RR1=4 RR2=5).
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = int'(rf_setRR1) + int'(rf_setRR2) + int'(rf_setWR) + int'(rf_setWData) + int'(rf_Wenable);
      if (n > 1) onehot_viol++;
      if (n == 0 && rf_p != 4'd0) idle_p_viol++;
      if (rf_setWR)    log_q.push_back({4'd1, rf_p});
      if (rf_setWData) log_q.push_back({4'd2, rf_p});
      if (rf_Wenable)  begin log_q.push_back({4'd3, 4'd0}); we_count++; end
      if (rf_setRR1)   log_q.push_back({4'd4, rf_p});
      if (rf_setRR2)   log_q.push_back({4'd5, rf_p});
    end
  end

  task automatic compare_log(input string tag);
    check_eq({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_eq(tag, log_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic clear_ref_valid();
    for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d);
    int k = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!cmd_ready) check_eq("accept_timeout", 0, 1);
    log_q.delete();
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] d, input bit check_seq);
    int k = 0;
    send_cmd(1'b0, a, 4'd0, d);
    do begin @(negedge clk); k++; end while (!cmd_ready && k < 20);
    ref_mem[a] = d;
    ref_vld[a] = 1'b1;
    if (check_seq) begin
      check_eq("wr_ready_cycle", k, 4);
      exp_q.push_back({4'd1, a});
      exp_q.push_back({4'd2, d});
      exp_q.push_back({4'd3, 4'd0});
      compare_log("wr_seq");
    end
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b, input int hold);
    int k = 0;
    bit stable = 1'b1;
    logic [3:0] ea, eb;
    logic em;
    ea = force_r1_zero ? 4'd0 : ref_mem[a];
    eb = ref_mem[b];
    em = SHADOW && ((ref_vld[a] && ea != ref_mem[a]) || (ref_vld[b] && eb != ref_mem[b]));
    send_cmd(1'b1, a, b, 4'd0);
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 30);
    check_eq("rd_latency", k, 5);
    exp_q.push_back({4'd4, a});
    exp_q.push_back({4'd5, b});
    compare_log("rd_seq");
    check_eq("rd_data_a", rsp_data_a, ea);
    check_eq("rd_data_b", rsp_data_b, eb);
    check_eq("rd_mismatch", rsp_mismatch, em);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_data_a != ea || rsp_data_b != eb || rsp_mismatch != em)
        stable = 1'b0;
    end
    if (hold > 0) check_eq("rsp_hold_stable", stable, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_release_valid", rsp_valid, 0);
    check_eq("rsp_release_ready", cmd_ready, 1);
    check_eq("rsp_release_mism", rsp_mismatch, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, we0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr_a = 4'd0; cmd_addr_b = 4'd0;
    cmd_data = 4'd0; rsp_ready = 1'b0;
    clear_ref_valid();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", {rsp_data_a, rsp_data_b}, 8'd0);
    check_eq("rst_mismatch", rsp_mismatch, 0);
    check_eq("rst_rf_bus", {rf_p, rf_setRR1, rf_setRR2, rf_setWR, rf_setWData, rf_Wenable}, 9'd0);
    rst = 1'b0;

    // Write then read the same address on both ports.
    do_write(4'd5, 4'hA, 1'b1);
    do_read(4'd5, 4'd5, 0);

    // Back-to-back writes with cmd_valid held high.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr_a = 4'd3; cmd_data = 4'h7;
    @(posedge clk);
    #1 cmd_addr_a = 4'd12; cmd_data = 4'hC;
    k = 0;
    do begin @(negedge clk); k++; end while (!cmd_ready && k < 20);
    check_eq("b2b_accept_gap", k, 4);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    ref_mem[3] = 4'h7;  ref_vld[3] = 1'b1;
    ref_mem[12] = 4'hC; ref_vld[12] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!cmd_ready && k < 20);
    do_read(4'd3, 4'd12, 0);

    // Response held off for 10 cycles.
    do_read(4'd5, 4'd3, 10);

    // Reset during W_DATA of 9 <- 1 must leave 9 at 4.
    do_write(4'd9, 4'h4, 1'b1);
    send_cmd(1'b0, 4'd9, 4'd0, 4'h1);
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_in_wdata", rf_setWData, 1);
    we0 = we_count;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_ref_valid();
    @(negedge clk);
    check_eq("abort_strobes_low", {rf_setRR1, rf_setRR2, rf_setWR, rf_setWData, rf_Wenable}, 5'd0);
    check_eq("abort_idle", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check_eq("abort_no_wenable", we_count, we0);
    do_read(4'd9, 4'd9, 0);

    // Reset while a response is pending drops it.
    send_cmd(1'b1, 4'd9, 4'd5, 4'd0);
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 30);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_ref_valid();
    @(negedge clk);
    check_eq("rst_drop_rsp_valid", rsp_valid, 0);
    check_eq("rst_drop_rsp_data", rsp_data_a, 0);
    check_eq("rst_drop_ready", cmd_ready, 1);

    // Fill all registers with their own address, read mirrored pairs.
    for (int i = 0; i < 16; i++) do_write(4'(i), 4'(i), 1'b0);
    for (int i = 0; i < 16; i++) do_read(4'(i), 4'(15 - i), 0);

    // Randomized mix of writes and reads.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      else
        do_read(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    // Shadow check: corrupt port 1 after writing 2 <- 6.
    do_write(4'd2, 4'h6, 1'b1);
    force_r1_zero = 1'b1;
    do_read(4'd2, 4'd2, 2);
    force_r1_zero = 1'b0;
    do_read(4'd2, 4'd2, 0);

    check_eq("strobe_onehot", onehot_viol, 0);
    check_eq("idle_bus_zero", idle_p_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
